johnson_counter_n: RTL

JOHNSON_COUNTER_N -- requirements
Module: johnson_counter_n

---
 rtl/johnson_pkg.sv | 33 +++
 rtl/johnson_code_rom.sv | 18 +
 rtl/johnson_counter_n.sv | 89 ++++++++
 3 files changed

// File: rtl/johnson_pkg.sv
// rtl/johnson_pkg.sv - shared Johnson-counter helpers: modulus, index-to-code and code-to-index.
package johnson_pkg;

  localparam int MAX_WIDTH = 16;

  function automatic int mod_of(input int width);
    return 2 * width;
  endfunction

  // Indices 0..width fill ones from the LSB; indices above width fill zeros from the LSB.
  function automatic logic [MAX_WIDTH-1:0] code(input int width, input int k);
    logic [MAX_WIDTH-1:0] c;
    c = '0;
    for (int i = 0; i < MAX_WIDTH; i++) begin
      if (i < width) begin
        if (k <= width) c[i] = (i < k);
        else            c[i] = (i >= k - width);
      end
    end
    return c;
  endfunction

  function automatic int decode(input int width, input logic [MAX_WIDTH-1:0] q);
    int ones;
    ones = 0;
    for (int i = 0; i < MAX_WIDTH; i++) begin
      if (i < width && q[i]) ones++;
    end
    if (q[0] || ones == 0) return ones;
    return 2 * width - ones;
  endfunction

endpackage

// File: rtl/johnson_code_rom.sv
// rtl/johnson_code_rom.sv - combinational map from a state index to its Johnson code plus range flag.
module johnson_code_rom
  import johnson_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int IW    = $clog2(2 * WIDTH)
) (
  input  logic [IW-1:0]    load_idx,
  output logic [WIDTH-1:0] code_o,
  output logic             valid
);

  always_comb begin
    valid  = (int'(load_idx) < mod_of(WIDTH));
    code_o = WIDTH'(code(WIDTH, int'(load_idx)));
  end

endmodule

// File: rtl/johnson_counter_n.sv
// rtl/johnson_counter_n.sv - up/down Johnson counter with load, wrap pulse and load-range error pulse.
module johnson_counter_n
  import johnson_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int IW    = $clog2(2 * WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             t,
  input  logic             dir,
  input  logic             load,
  input  logic [IW-1:0]    load_idx,
  output logic [WIDTH-1:0] Q,
  output logic [IW-1:0]    idx,
  output logic             tc,
  output logic             load_err
);

  localparam int          MOD  = mod_of(WIDTH);
  localparam logic [IW-1:0] LAST = IW'(MOD - 1);

  logic [WIDTH-1:0] q_q, q_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             tc_q, tc_d;
  logic             load_err_q, load_err_d;
  logic [WIDTH-1:0] rom_code;
  logic             rom_valid;

  johnson_code_rom #(.WIDTH(WIDTH), .IW(IW)) u_rom (
    .load_idx (load_idx),
    .code_o   (rom_code),
    .valid    (rom_valid)
  );

  always_comb begin
    q_d        = q_q;
    idx_d      = idx_q;
    tc_d       = 1'b0;
    load_err_d = 1'b0;
    if (load) begin
      // An out-of-range load freezes the counter for that edge, counting included.
      if (rom_valid) begin
        q_d   = rom_code;
        idx_d = load_idx;
      end else begin
        load_err_d = 1'b1;
      end
    end else if (t) begin
      if (!dir) begin
        q_d = {q_q[WIDTH-2:0], ~q_q[WIDTH-1]};
        if (idx_q == LAST) begin
          idx_d = '0;
          tc_d  = 1'b1;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end else begin
        q_d = {~q_q[0], q_q[WIDTH-1:1]};
        if (idx_q == '0) begin
          idx_d = LAST;
          tc_d  = 1'b1;
        end else begin
          idx_d = idx_q - IW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q        <= '0;
      idx_q      <= '0;
      tc_q       <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      q_q        <= q_d;
      idx_q      <= idx_d;
      tc_q       <= tc_d;
      load_err_q <= load_err_d;
    end
  end

  assign Q        = q_q;
  assign idx      = idx_q;
  assign tc       = tc_q;
  assign load_err = load_err_q;

endmodule
